// File: rtl/coder_output_packer_if.sv
// Bus bundle for coder_output_packer: encoder triplet input side and byte-stream output side.
// The master modport is the surrounding logic; the slave modport is the packer itself.
interface coder_output_packer_if #(
    parameter int SIZE_W = 16
);
    logic              enc_valid;
    logic              enc_start;
    logic              xk_in;
    logic              zk_in;
    logic              zk_prime_in;
    logic [SIZE_W-1:0] blk_size;
    logic [7:0]        byte_out;
    logic              byte_last;
    logic              byte_valid;
    logic              byte_ready;
    logic              blk_done;
    logic              busy;
    logic              overflow;
    logic              proto_err;

    modport master (
        output enc_valid, enc_start, xk_in, zk_in, zk_prime_in, blk_size, byte_ready,
        input  byte_out, byte_last, byte_valid, blk_done, busy, overflow, proto_err
    );

    modport slave (
        input  enc_valid, enc_start, xk_in, zk_in, zk_prime_in, blk_size, byte_ready,
        output byte_out, byte_last, byte_valid, blk_done, busy, overflow, proto_err
    );
endinterface

// File: rtl/coder_output_packer.sv
// Packs encoder triplets (xk, zk, zk') of one code block, tail included, into LSB-first bytes
// and queues them with a last-of-block flag in a small FIFO for a valid/ready consumer.
module coder_output_packer #(
    parameter int SIZE_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    coder_output_packer_if.slave  bus
);
    localparam int CW = SIZE_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      acc_q, acc_d;
    logic [3:0]      acc_cnt_q, acc_cnt_d;
    logic [CW-1:0]   trip_cnt_q, trip_cnt_d;
    logic [CW-1:0]   target_q, target_d;
    logic            overflow_q;
    logic            proto_err_q;

    logic            accept;
    logic            restart;
    logic [2:0]      trip_bits;
    logic [9:0]      base_acc;
    logic [3:0]      base_cnt;
    logic [CW-1:0]   base_trip;
    logic [CW-1:0]   target_now;
    logic [9:0]      sum_acc;
    logic [3:0]      sum_cnt;
    logic            full_byte;
    logic [9:0]      rem_acc;
    logic [3:0]      rem_cnt;
    logic            final_trip;

    logic            wr_req;
    logic [7:0]      wr_data;
    logic            wr_last;
    logic            proto_hit;

    logic [8:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   fifo_cnt;
    logic               fifo_full, fifo_empty;
    logic               push, pop, drop;

    // A start strobe always restarts from an empty accumulator, which is how a
    // mid-block restart throws away the partial residual.
    assign restart    = bus.enc_valid && bus.enc_start;
    assign accept     = bus.enc_valid &&
                        ((state_q == ST_COLLECT) || ((state_q == ST_IDLE) && bus.enc_start));
    assign trip_bits  = {bus.zk_prime_in, bus.zk_in, bus.xk_in};
    assign base_acc   = restart ? '0 : acc_q;
    assign base_cnt   = restart ? '0 : acc_cnt_q;
    assign base_trip  = restart ? '0 : trip_cnt_q;
    assign target_now = restart ? ({1'b0, bus.blk_size} + CW'(4)) : target_q;
    assign sum_acc    = base_acc | ({7'b0, trip_bits} << base_cnt);
    assign sum_cnt    = base_cnt + 4'd3;
    assign full_byte  = (sum_cnt >= 4'd8);
    assign rem_acc    = full_byte ? {8'b0, sum_acc[9:8]} : sum_acc;
    assign rem_cnt    = full_byte ? (sum_cnt - 4'd8) : sum_cnt;
    assign final_trip = ((base_trip + CW'(1)) == target_now);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        acc_cnt_d  = acc_cnt_q;
        trip_cnt_d = trip_cnt_q;
        target_d   = target_q;
        wr_req     = 1'b0;
        wr_data    = '0;
        wr_last    = 1'b0;
        proto_hit  = 1'b0;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (accept) begin
                    proto_hit  = (state_q == ST_COLLECT) && bus.enc_start;
                    acc_d      = rem_acc;
                    acc_cnt_d  = rem_cnt;
                    trip_cnt_d = base_trip + CW'(1);
                    target_d   = target_now;
                    wr_req     = full_byte;
                    wr_data    = sum_acc[7:0];
                    if (!final_trip) begin
                        state_d = ST_COLLECT;
                    end else if (rem_cnt == 4'd0) begin
                        wr_last = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Bits above the residual count are always zero, giving MSB padding for free.
                wr_req    = 1'b1;
                wr_data   = acc_q[7:0];
                wr_last   = 1'b1;
                acc_d     = '0;
                acc_cnt_d = '0;
                state_d   = ST_IDLE;
                proto_hit = bus.enc_valid;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fifo_full  = (fifo_cnt == (FIFO_AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = bus.byte_ready && !fifo_empty;
    assign push       = wr_req && (!fifo_full || pop);
    assign drop       = wr_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            trip_cnt_q  <= '0;
            target_q    <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            acc_cnt_q  <= acc_cnt_d;
            trip_cnt_q <= trip_cnt_d;
            target_q   <= target_d;
            if (drop) begin
                overflow_q <= 1'b1;
            end
            if (proto_hit) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {wr_last, wr_data};
                wr_ptr <= (wr_ptr == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == FIFO_AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (FIFO_AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (FIFO_AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // The head entry is masked while empty so the uninitialised storage never leaks out.
    assign bus.byte_out   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr][7:0];
    assign bus.byte_last  = fifo_empty ? 1'b0  : fifo_mem[rd_ptr][8];
    assign bus.byte_valid = !fifo_empty;
    assign bus.blk_done   = wr_req && wr_last && !reset;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.overflow   = overflow_q;
    assign bus.proto_err  = proto_err_q;
endmodule

// File: tb/tb_coder_output_packer.sv
// Self-checking bench for coder_output_packer: table of block vectors plus hand-written
// sequences for overflow, mid-block restart, mid-block reset and triplets arriving in FLUSH.
`timescale 1ns/1ps
module tb_coder_output_packer;
    localparam int SIZE_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    coder_output_packer_if #(.SIZE_W(SIZE_W)) bus ();

    coder_output_packer #(
        .SIZE_W(SIZE_W),
        .FIFO_DEPTH(16),
        .FIFO_AW(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        int k;
        int pattern;
        int gap;
        int ready_mode;
        int exp_bytes;
    } vec_t;

    vec_t       vecs [6];
    int         checks = 0;
    int         errors = 0;
    int         ready_mode = 1;
    int         done_cnt = 0;
    logic [8:0] got [$];
    logic       ref_bits [$];
    logic [7:0] hand_tbl [3];

    // Consumer: 0 = stalled, 1 = always ready, 2 = random.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 2) bus.byte_ready = 1'($urandom_range(0, 1));
        else                 bus.byte_ready = (ready_mode == 1);
    end

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (bus.byte_valid && bus.byte_ready) got.push_back({bus.byte_last, bus.byte_out});
            if (bus.blk_done) done_cnt++;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.enc_valid = 1'b0;
        bus.enc_start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.enc_valid = 1'b0;
            bus.enc_start = 1'b0;
        end
    endtask

    task automatic sendTriplet(input int k, input bit start, input int pattern);
        logic x, z, zp;
        if (pattern == 0) begin
            x = 1'b1; z = 1'b0; zp = 1'b0;
        end else begin
            x = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            zp = 1'($urandom_range(0, 1));
        end
        ref_bits.push_back(x);
        ref_bits.push_back(z);
        ref_bits.push_back(zp);
        @(posedge clk); #1;
        bus.enc_valid   = 1'b1;
        bus.enc_start   = start;
        bus.xk_in       = x;
        bus.zk_in       = z;
        bus.zk_prime_in = zp;
        bus.blk_size    = SIZE_W'(k);
    endtask

    task automatic applyStimulus(input int k, input int pattern, input int gap, input int ntrip);
        for (int i = 0; i < ntrip; i++) begin
            sendTriplet(k, (i == 0), pattern);
            if (gap > 0) idleCycles(gap);
        end
        idleCycles(1);
    endtask

    task automatic waitBytes(input string name, input int n);
        int cyc = 0;
        while (got.size() < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (6) @(negedge clk);
        checkOutput({name, " byte count"}, got.size(), n);
    endtask

    function automatic logic [7:0] refByte(input int first_bit, input int idx);
        logic [7:0] b = '0;
        for (int j = 0; j < 8; j++) begin
            int p = first_bit + 8 * idx + j;
            if (p < ref_bits.size()) b[j] = ref_bits[p];
        end
        return b;
    endfunction

    task automatic checkRefBlock(input string name, input int first_bit, input int first_got, input int n);
        for (int i = 0; i < n; i++) begin
            if (first_got + i < got.size()) begin
                checkOutput($sformatf("%s byte%0d", name, i), got[first_got + i][7:0], refByte(first_bit, i));
                checkOutput($sformatf("%s last%0d", name, i), got[first_got + i][8], (i == n - 1));
            end
        end
    endtask

    // Pattern xk=1 only: bytes cycle 0x49,0x92,0x24; a K=40 block ends with 0x02.
    task automatic checkHandBlock(input string name, input int n, input bit has_tail);
        for (int i = 0; i < n && i < got.size(); i++) begin
            logic [7:0] eb;
            eb = (has_tail && i == n - 1) ? 8'h02 : hand_tbl[i % 3];
            checkOutput($sformatf("%s byte%0d", name, i), got[i][7:0], eb);
            checkOutput($sformatf("%s last%0d", name, i), got[i][8], (has_tail && i == n - 1));
        end
    endtask

    task automatic clearRun();
        got.delete();
        ref_bits.delete();
        done_cnt = 0;
    endtask

    initial begin
        reset = 1'b1;
        bus.enc_valid = 1'b0;
        bus.enc_start = 1'b0;
        bus.xk_in = 1'b0;
        bus.zk_in = 1'b0;
        bus.zk_prime_in = 1'b0;
        bus.blk_size = '0;
        hand_tbl[0] = 8'h49;
        hand_tbl[1] = 8'h92;
        hand_tbl[2] = 8'h24;
        vecs[0] = '{k: 40, pattern: 0, gap: 0, ready_mode: 1, exp_bytes: 17};
        vecs[1] = '{k: 4,  pattern: 1, gap: 0, ready_mode: 1, exp_bytes: 3};
        vecs[2] = '{k: 0,  pattern: 1, gap: 0, ready_mode: 1, exp_bytes: 2};
        vecs[3] = '{k: 12, pattern: 1, gap: 0, ready_mode: 1, exp_bytes: 6};
        vecs[4] = '{k: 40, pattern: 0, gap: 1, ready_mode: 2, exp_bytes: 17};
        vecs[5] = '{k: 1,  pattern: 1, gap: 2, ready_mode: 2, exp_bytes: 2};

        doReset();
        @(negedge clk);
        checkOutput("reset byte_valid", bus.byte_valid, 0);
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset overflow", bus.overflow, 0);
        checkOutput("reset proto_err", bus.proto_err, 0);
        checkOutput("reset blk_done", bus.blk_done, 0);

        for (int v = 0; v < 6; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            ready_mode = vecs[v].ready_mode;
            clearRun();
            applyStimulus(vecs[v].k, vecs[v].pattern, vecs[v].gap, vecs[v].k + 4);
            waitBytes(nm, vecs[v].exp_bytes);
            if (vecs[v].pattern == 0) checkHandBlock(nm, vecs[v].exp_bytes, 1'b1);
            else                      checkRefBlock(nm, 0, 0, vecs[v].exp_bytes);
            checkOutput({nm, " blk_done pulses"}, done_cnt, 1);
            checkOutput({nm, " overflow"}, bus.overflow, 0);
            checkOutput({nm, " proto_err"}, bus.proto_err, 0);
            checkOutput({nm, " busy idle"}, bus.busy, 0);
        end

        // Stalled consumer: 16 bytes fit, the flushed 17th is dropped.
        ready_mode = 0;
        doReset();
        clearRun();
        applyStimulus(40, 0, 0, 44);
        idleCycles(3);
        @(negedge clk);
        checkOutput("ovf overflow", bus.overflow, 1);
        checkOutput("ovf blk_done pulses", done_cnt, 1);
        checkOutput("ovf byte_valid", bus.byte_valid, 1);
        ready_mode = 1;
        waitBytes("ovf", 16);
        checkHandBlock("ovf", 16, 1'b0);

        // Restart mid-block: 10 triplets of K=40, then a K=4 block.
        doReset();
        clearRun();
        for (int i = 0; i < 10; i++) sendTriplet(40, (i == 0), 0);
        applyStimulus(4, 1, 0, 8);
        waitBytes("restart", 6);
        checkHandBlock("restart", 3, 1'b0);
        checkRefBlock("restart tail", 30, 3, 3);
        checkOutput("restart proto_err", bus.proto_err, 1);
        checkOutput("restart blk_done pulses", done_cnt, 1);

        // Reset at triplet 20 of a K=40 block with bytes pending and proto_err still set.
        ready_mode = 0;
        idleCycles(2);
        clearRun();
        for (int i = 0; i < 20; i++) sendTriplet(40, (i == 0), 0);
        @(negedge clk);
        checkOutput("midrst pre busy", bus.busy, 1);
        checkOutput("midrst pre byte_valid", bus.byte_valid, 1);
        @(posedge clk); #1;
        bus.enc_valid = 1'b0;
        bus.enc_start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrst byte_valid", bus.byte_valid, 0);
        checkOutput("midrst busy", bus.busy, 0);
        checkOutput("midrst proto_err", bus.proto_err, 0);
        checkOutput("midrst overflow", bus.overflow, 0);
        ready_mode = 1;
        clearRun();
        applyStimulus(4, 1, 0, 8);
        waitBytes("midrst k4", 3);
        checkRefBlock("midrst k4", 0, 0, 3);

        // A triplet arriving during the flush cycle is dropped and flagged.
        clearRun();
        for (int i = 0; i < 4; i++) sendTriplet(0, (i == 0), 1);
        @(posedge clk); #1;
        bus.enc_valid = 1'b1;
        bus.enc_start = 1'b0;
        bus.xk_in = 1'b1;
        bus.zk_in = 1'b1;
        bus.zk_prime_in = 1'b1;
        idleCycles(2);
        waitBytes("flushvalid", 2);
        checkRefBlock("flushvalid", 0, 0, 2);
        checkOutput("flushvalid proto_err", bus.proto_err, 1);
        checkOutput("flushvalid blk_done pulses", done_cnt, 1);
        checkOutput("flushvalid busy", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
